private_ram_arbiter: RTL

PRIVATE_RAM_ARBITER -- requirements
Module: private_ram_arbiter

---
 rtl/private_ram_arb_pkg.sv | 12 +
 rtl/private_ram_rr_arb.sv | 21 ++
 rtl/private_ram_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/private_ram_arb_pkg.sv
// Shared definitions for the private RAM bank arbiter: FSM state encoding and
// the fixed requester count.
package private_ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/private_ram_rr_arb.sv
// Two-way round-robin decision: a lone request wins outright, a tie goes to the
// master selected by ptr_i. Output is one-hot or zero.
module private_ram_rr_arb
  import private_ram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/private_ram_arbiter.sv
// Private RAM bank arbiter: zero-fills the bank after reset, then shares it
// between two masters round-robin. Optional conflict counter: PRIVATE_RAM_ARB_PERF_EN.
module private_ram_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_MASTERS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][3:0]            be_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][31:0]           wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [1:0][31:0]           rdata_o,
  output logic                       ram_csn_o,
  output logic                       ram_wen_o,
  output logic [3:0]                 ram_be_o,
  output logic [ADDR_WIDTH-1:0]      ram_addr_o,
  output logic [31:0]                ram_wdata_o,
  input  logic [31:0]                ram_rdata_i,
  output logic                       init_done_o,
  input  logic                       perf_clr_i,
  output logic [31:0]                conflict_cnt_o
);

  import private_ram_arb_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_rr_ptr;
  logic [1:0]            r_rvalid;
  logic [1:0]            w_arb_gnt;
  logic [1:0]            w_gnt;
  logic                  w_init_wr;
  logic                  w_sel;

  private_ram_rr_arb u_rr_arb (
    .req_i (req_i),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_arb_gnt)
  );

  // Bank writes are suppressed while reset is held so the bank sees an idle port.
  always_comb begin
    w_state_next = r_state;
    w_gnt        = 2'b00;
    w_init_wr    = 1'b0;
    case (r_state)
      INIT: begin
        w_init_wr = ~rst_i;
        if (&r_init_cnt) w_state_next = RUN;
      end
      RUN:     w_gnt = w_arb_gnt;
      default: w_state_next = INIT;
    endcase
  end

  assign w_sel = w_gnt[1];

  always_comb begin
    ram_csn_o   = 1'b1;
    ram_wen_o   = 1'b1;
    ram_be_o    = be_i[w_sel];
    ram_addr_o  = addr_i[w_sel];
    ram_wdata_o = wdata_i[w_sel];
    if (w_init_wr) begin
      ram_csn_o   = 1'b0;
      ram_wen_o   = 1'b0;
      ram_be_o    = 4'hF;
      ram_addr_o  = r_init_cnt;
      ram_wdata_o = 32'h0;
    end else if (|w_gnt) begin
      ram_csn_o = 1'b0;
      ram_wen_o = ~we_i[w_sel];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_rr_ptr   <= 1'b0;
      r_rvalid   <= 2'b00;
    end else begin
      r_state  <= w_state_next;
      r_rvalid <= w_gnt;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (|w_gnt) r_rr_ptr <= w_gnt[0];
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid;
  assign init_done_o = (r_state == RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
      assign rdata_o[gi] = r_rvalid[gi] ? ram_rdata_i : 32'h0;
    end
  endgenerate

`ifdef PRIVATE_RAM_ARB_PERF_EN
  logic [31:0] r_conflict_cnt;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict_cnt <= 32'h0;
    end else if (perf_clr_i) begin
      r_conflict_cnt <= 32'h0;
    end else if ((r_state == RUN) && (req_i == 2'b11) && !(&r_conflict_cnt)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'h1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr_i;
  assign conflict_cnt_o    = 32'h0;
`endif

endmodule
